// File: rtl/sd_serial_tx.sv
// Parallel-to-serial shifter with a one-word holding buffer.
// Streams WIDTH-bit words one bit per enabled clock to a serial detector.
module sd_serial_tx #(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             signal,
    output logic             bit_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             hold_valid, hold_valid_n;
    logic             fd_n;
    logic             xfer;
    logic             head;
    logic [WIDTH-1:0] shifted;

    assign head    = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
    assign shifted = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0}
                                      : {1'b0, sreg[WIDTH-1:1]};

    assign din_ready = (state == IDLE) | ~hold_valid;
    assign xfer      = din_valid & din_ready;
    assign signal    = (state == SHIFT) ? head : IDLE_BIT;
    assign bit_valid = (state == SHIFT);
    assign busy      = (state == SHIFT) | hold_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sreg       <= '0;
            hold       <= '0;
            cnt        <= '0;
            hold_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            sreg       <= sreg_n;
            hold       <= hold_n;
            cnt        <= cnt_n;
            hold_valid <= hold_valid_n;
            frame_done <= fd_n;
        end
    end

    always_comb begin
        state_n      = state;
        sreg_n       = sreg;
        hold_n       = hold;
        cnt_n        = cnt;
        hold_valid_n = hold_valid;
        fd_n         = 1'b0;
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    sreg_n  = din;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (en && cnt == LAST) begin
                    fd_n  = 1'b1;
                    cnt_n = '0;
                    // Refill from hold or straight from din so words run gap-free.
                    if (hold_valid) begin
                        sreg_n       = hold;
                        hold_valid_n = 1'b0;
                    end else if (xfer) begin
                        sreg_n = din;
                    end else begin
                        sreg_n  = '0;
                        state_n = IDLE;
                    end
                end else begin
                    if (en) begin
                        sreg_n = shifted;
                        cnt_n  = cnt + 1'b1;
                    end
                    if (xfer) begin
                        hold_n       = din;
                        hold_valid_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sd_serial_tx.sv
// Scoreboard bench for sd_serial_tx: 8-bit MSB-first and 4-bit LSB-first
// instances, checking bit order, gaps, stalls, frame_done and reset.
module tb_sd_serial_tx;

    typedef struct {
        logic b;
        logic last;
    } exp_bit_t;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       en;
    logic       signal;
    logic       bit_valid;
    logic       busy;
    logic       frame_done;

    logic [3:0] din2;
    logic       din2_valid;
    logic       din2_ready;
    logic       en2;
    logic       signal2;
    logic       bit_valid2;
    logic       busy2;
    logic       frame_done2;

    int tests;
    int fails;

    exp_bit_t q1[$];
    exp_bit_t q2[$];
    logic     fd1;
    logic     fd2;

    sd_serial_tx #(.WIDTH(8), .MSB_FIRST(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .en         (en),
        .signal     (signal),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    sd_serial_tx #(.WIDTH(4), .MSB_FIRST(0)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .din        (din2),
        .din_valid  (din2_valid),
        .din_ready  (din2_ready),
        .en         (en2),
        .signal     (signal2),
        .bit_valid  (bit_valid2),
        .busy       (busy2),
        .frame_done (frame_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Monitor for the 8-bit instance; pushes expected bits on accepted words.
    always @(negedge clk) begin
        if (!rst) begin
            q1.delete();
            fd1 = 1'b0;
        end else begin
            chk("frame_done", {31'b0, frame_done}, {31'b0, fd1});
            fd1 = 1'b0;
            chk("bit_valid", {31'b0, bit_valid}, {31'b0, q1.size() != 0});
            if (bit_valid && q1.size() != 0) begin
                chk("bit", {31'b0, signal}, {31'b0, q1[0].b});
                if (en) begin
                    fd1 = q1[0].last;
                    void'(q1.pop_front());
                end
            end else if (!bit_valid) begin
                chk("idle_level", {31'b0, signal}, 32'd0);
            end
            if (din_valid && din_ready)
                for (int i = 0; i < 8; i++)
                    q1.push_back('{din[7-i], i == 7});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            q2.delete();
            fd2 = 1'b0;
        end else begin
            chk("frame_done2", {31'b0, frame_done2}, {31'b0, fd2});
            fd2 = 1'b0;
            chk("bit_valid2", {31'b0, bit_valid2}, {31'b0, q2.size() != 0});
            if (bit_valid2 && q2.size() != 0) begin
                chk("bit2", {31'b0, signal2}, {31'b0, q2[0].b});
                if (en2) begin
                    fd2 = q2[0].last;
                    void'(q2.pop_front());
                end
            end
            if (din2_valid && din2_ready)
                for (int i = 0; i < 4; i++)
                    q2.push_back('{din2[i], i == 3});
        end
    end

    task automatic send8(input logic [7:0] w);
        bit done;
        done = 1'b0;
        din = w;
        din_valid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (din_ready) begin
                @(posedge clk);
                #1;
                din_valid = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            din_valid = 1'b0;
            chk("handshake_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic send4(input logic [3:0] w);
        bit done;
        done = 1'b0;
        din2 = w;
        din2_valid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (din2_ready) begin
                @(posedge clk);
                #1;
                din2_valid = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            din2_valid = 1'b0;
            chk("handshake_timeout2", 32'd0, 32'd1);
        end
    endtask

    task automatic chk_reset_outs;
        chk("rst_signal", {31'b0, signal}, 32'd0);
        chk("rst_bit_valid", {31'b0, bit_valid}, 32'd0);
        chk("rst_din_ready", {31'b0, din_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        din = '0;
        din_valid = 1'b0;
        en = 1'b1;
        din2 = '0;
        din2_valid = 1'b0;
        en2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs();
        rst = 1'b1;

        // Single word A5
        send8(8'hA5);
        repeat (12) @(posedge clk);
        #1;
        chk("idle_busy", {31'b0, busy}, 32'd0);

        // Back-to-back A5, 0F through the holding buffer
        send8(8'hA5);
        send8(8'h0F);
        @(negedge clk);
        chk("held_din_ready", {31'b0, din_ready}, 32'd0);
        chk("held_busy", {31'b0, busy}, 32'd1);
        repeat (20) @(posedge clk);
        #1;

        // Stall three cycles while bit 3 is presented
        send8(8'hA5);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        // Bypass: next word offered only during the last bit
        send8(8'hA5);
        repeat (7) @(posedge clk);
        #1;
        send8(8'h3C);
        repeat (12) @(posedge clk);
        #1;

        // Reset mid-frame with a word held
        send8(8'hA5);
        send8(8'h0F);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_outs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        send8(8'h05);
        repeat (12) @(posedge clk);
        #1;

        // LSB-first 4-bit instance
        send4(4'b0101);
        repeat (8) @(posedge clk);
        #1;
        chk("busy2_end", {31'b0, busy2}, 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        chk("q2_drained", q2.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
